mips_muldiv_unit: RTL and testbench
===================================

// Module: mips_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit with HI/LO registers for the MIPS core: MULT, MULTU, DIV, DIVU.
//  Sits beside the ALU. The decoder issues start/op, and the core stalls while busy=1.
//  MFHI/MFLO read hi/lo directly; MTHI/MTLO write through mthi/mtlo.
//  Parametrised in datapath width; one result bit per clock; fixed latency.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are each WIDTH bits; product is 2*WIDTH bits
//  CNT_W  $clog2(WIDTH+1)  iteration counter width (localparam, derived; not overridable)
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-low (reset==0 resets immediately)
//  start        in   1      launch op on a/b; honoured only when busy==0
//  op           in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//  a            in   WIDTH  rs operand (multiplicand / dividend), sampled with start
//  b            in   WIDTH  rt operand (multiplier / divisor), sampled with start
//  mthi         in   1      write wdata to HI (idle only)
//  mtlo         in   1      write wdata to LO (idle only)
//  wdata        in   WIDTH  MTHI/MTLO data
//  busy         out  1      1 while an operation is in flight (state!=IDLE)
//  done         out  1      one-cycle pulse: hi/lo hold the new result this cycle
//  hi           out  WIDTH  HI register (mult: upper product; div: remainder)
//  lo           out  WIDTH  LO register (mult: lower product; div: quotient)
//  div_by_zero  out  1      set when the last completed DIV/DIVU had b==0; updated only at completion
// BEHAVIOUR
//  Reset (any cycle, including mid-operation): state=IDLE; counter=0; hi=lo=0; busy=done=div_by_zero=0.
//  FSM: IDLE -> (start) MUL|DIV -> FIX -> IDLE.
//   IDLE: on start, latch |a|,|b| (magnitudes for signed ops, raw for unsigned) and result-sign flags.
//    Also clear accumulator; counter=0. Go to MUL (op[1]=0) or DIV (op[1]=1).
//   MUL: shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator; WIDTH cycles.
//   DIV: restoring division, one quotient bit per cycle; WIDTH cycles.
//   Both MUL and DIV leave for FIX when counter==WIDTH-1.
//   FIX: apply sign correction and write hi/lo (and div_by_zero for divides) at the FIX clock edge.
//  Latency: start sampled at edge 0; busy=1 from edge 1 through edge WIDTH+1.
//   done=1 and busy=0 in the cycle after edge WIDTH+1 (WIDTH+2 cycles total, 34 for WIDTH=32).
//  Back-to-back: start in the done cycle is accepted (state is IDLE).
//  start while busy: ignored. op/a/b changes while busy: no effect.
//  mthi/mtlo: write at next edge only when busy==0 and start==0.
//   If start and mthi/mtlo are asserted in the same cycle, start wins and the write is dropped.
//   Writes while busy are dropped; mthi and mtlo together write both registers.
//  Signed rules:
//   MULT: product negated iff sign(a)^sign(b).
//   DIV: quotient negated iff sign(a)^sign(b); remainder takes sign(a).
//   DIV MIN/-1: lo=MIN (e.g. 32'h80000000), hi=0. No trap.
//  Divide by zero (b==0, DIV or DIVU): full latency; hi=a (as issued); lo={WIDTH{1'b1}}; div_by_zero=1.
//  div_by_zero: cleared at completion of any op with no zero divisor; unaffected by mthi/mtlo.
//  hi/lo hold their value between operations and change only at the FIX edge, at MTHI/MTLO, or at reset.
// STRUCTURE
//  Package mips_muldiv_pkg:
//   op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU; FSM state enum {IDLE,MUL,DIV,FIX}.
//  Sub-module mips_cond_neg #(W): combinational conditional two's-complement (out = neg ? -in : in).
//   Instantiated for operand magnitudes and for result sign fixes.
//  All other logic, including the FSM, counter and shift registers, stays in this module.
// TESTING (WIDTH=32)
//  1. MULTU a=32'hFFFFFFFF b=32'hFFFFFFFF -> done at cycle 34; hi=32'hFFFFFFFE, lo=32'h00000001.
//  2. MULT a=-7 b=3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB. Then DIV a=-7 b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
//  3. DIVU a=100 b=0 -> hi=100, lo=32'hFFFFFFFF, div_by_zero=1. Then DIVU 100/7 -> lo=14, hi=2, div_by_zero=0.
//  4. DIV a=32'h80000000 b=32'hFFFFFFFF -> lo=32'h80000000, hi=0, div_by_zero=0.
//  5. Idle mthi wdata=5 then mtlo wdata=9 -> hi=5, lo=9.
//   Then mthi during busy, and mthi together with start -> both writes dropped.
//   A second start pulsed mid-op is ignored; a start in the done cycle is accepted.
//  6. Drive reset=0 at cycle 10 of a DIV -> immediately busy=0, done=0, hi=lo=0.
//   Release reset, issue MULTU 3*4 -> lo=12 after 34 cycles.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op encodings and FSM states.
package mips_muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/mips_cond_neg.sv
// Conditional two's-complement: result = neg ? -value : value.
module mips_cond_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; one result bit per clock.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opa_reg;
    logic [WIDTH-1:0]   opb_reg;
    logic               res_neg;
    logic               rem_neg;
    logic               div_zero;
    logic               div_mode;

    logic               signed_op;
    logic               is_div_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_fits;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy      = (state != IDLE);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];

    mips_cond_neg #(.W(WIDTH)) u_mag_a (.value(a), .neg(a_neg), .result(a_mag));
    mips_cond_neg #(.W(WIDTH)) u_mag_b (.value(b), .neg(b_neg), .result(b_mag));

    mips_cond_neg #(.W(2*WIDTH)) u_fix_prod (.value(acc), .neg(res_neg), .result(prod_fix));
    mips_cond_neg #(.W(WIDTH)) u_fix_quo (.value(opa_reg), .neg(res_neg), .result(quo_fix));
    mips_cond_neg #(.W(WIDTH)) u_fix_rem (.value(acc[2*WIDTH-1:WIDTH]), .neg(rem_neg), .result(rem_fix));

    // One shift-add step and one restoring-divide trial subtraction, computed from the current registers.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opa_reg[0] ? {1'b0, opb_reg} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], opa_reg[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, opb_reg});
        div_diff  = div_shift[WIDTH-1:0] - opb_reg;
    end

    // Control FSM with iteration datapath, HI/LO writes and registered done/div_by_zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            acc         <= '0;
            opa_reg     <= '0;
            opb_reg     <= '0;
            res_neg     <= 1'b0;
            rem_neg     <= 1'b0;
            div_zero    <= 1'b0;
            div_mode    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa_reg  <= a_mag;
                        opb_reg  <= b_mag;
                        acc      <= '0;
                        count    <= '0;
                        res_neg  <= a_neg ^ b_neg;
                        rem_neg  <= a_neg;
                        div_mode <= is_div_op;
                        div_zero <= is_div_op && (b == '0);
                        state    <= is_div_op ? DIV : MUL;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                MUL: begin
                    acc     <= {mul_sum, acc[WIDTH-1:1]};
                    opa_reg <= opa_reg >> 1;
                    count   <= count + 1'b1;
                    if (count == LAST) state <= FIX;
                end
                DIV: begin
                    acc[2*WIDTH-1:WIDTH] <= div_fits ? div_diff : div_shift[WIDTH-1:0];
                    opa_reg <= {opa_reg[WIDTH-2:0], div_fits};
                    count   <= count + 1'b1;
                    if (count == LAST) state <= FIX;
                end
                FIX: begin
                    if (div_mode) begin
                        hi <= rem_fix;
                        lo <= div_zero ? '1 : quo_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    div_by_zero <= div_zero;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit with an arithmetic reference model of HI/LO/div_by_zero.
module tb_mips_muldiv_unit;

    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;
    string cur_step = "init";

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_dbz = 1'b0;

    mips_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .mthi(mthi),
        .mtlo(mtlo),
        .wdata(wdata),
        .busy(busy),
        .done(done),
        .hi(hi),
        .lo(lo),
        .div_by_zero(div_by_zero)
    );

    // Free-running 10ns clock.
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s/%s: observed %0h expected %0h", cur_step, tag, obs, exp);
        end
    endtask

    // Architectural result of one operation, from plain 64-bit arithmetic.
    task automatic refModel(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, sr;
        longint unsigned ux, uy, ur;
        sx = $signed(x);
        sy = $signed(y);
        ux = x;
        uy = y;
        case (o)
            2'b00: begin
                sr = sx * sy;
                m_hi = sr[63:32]; m_lo = sr[31:0]; m_dbz = 1'b0;
            end
            2'b01: begin
                ur = ux * uy;
                m_hi = ur[63:32]; m_lo = ur[31:0]; m_dbz = 1'b0;
            end
            2'b10: begin
                if (y == 32'd0) begin
                    m_hi = x; m_lo = '1; m_dbz = 1'b1;
                end else begin
                    sr = sx / sy; m_lo = sr[31:0];
                    sr = sx % sy; m_hi = sr[31:0];
                    m_dbz = 1'b0;
                end
            end
            default: begin
                if (y == 32'd0) begin
                    m_hi = x; m_lo = '1; m_dbz = 1'b1;
                end else begin
                    ur = ux / uy; m_lo = ur[31:0];
                    ur = ux % uy; m_hi = ur[31:0];
                    m_dbz = 1'b0;
                end
            end
        endcase
    endtask

    // Issue one op (caller is at a negedge), optionally disturb it, wait for done and check results.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input bit mthi_with_start, input bit disturb);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int lat;
        old_hi = m_hi;
        old_lo = m_lo;
        start = 1'b1; op = o; a = x; b = y;
        mthi = mthi_with_start; wdata = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        checkOutput("done_low_in_flight", 64'(done), 64'd0);
        checkOutput("hi_held_at_start", 64'(hi), 64'(old_hi));
        checkOutput("lo_held_at_start", 64'(lo), 64'(old_lo));
        lat = 0;
        while (!done && lat < 100) begin
            if (disturb && lat == 10) begin
                start = 1'b1; op = 2'($urandom); mthi = 1'b1; mtlo = 1'b1; wdata = 32'h12345678;
            end else begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (disturb && lat == 20) begin
                checkOutput("hi_held_busy_write", 64'(hi), 64'(old_hi));
                checkOutput("lo_held_busy_write", 64'(lo), 64'(old_lo));
            end
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        checkOutput("latency", 64'(lat), 64'(WIDTH + 1));
        checkOutput("busy_at_done", 64'(busy), 64'd0);
        refModel(o, x, y);
        checkOutput("hi", 64'(hi), 64'(m_hi));
        checkOutput("lo", 64'(lo), 64'(m_lo));
        checkOutput("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
    endtask

    initial begin
        $display("[TB] starting");
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cur_step = "reset";
        checkOutput("busy", 64'(busy), 64'd0);
        checkOutput("done", 64'(done), 64'd0);
        checkOutput("hi", 64'(hi), 64'd0);
        checkOutput("lo", 64'(lo), 64'd0);
        checkOutput("div_by_zero", 64'(div_by_zero), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        cur_step = "multu_max";
        applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        checkOutput("hi_const", 64'(hi), 64'hFFFFFFFE);
        checkOutput("lo_const", 64'(lo), 64'h00000001);

        cur_step = "mult_neg";
        @(negedge clk);
        applyStimulus(2'b00, 32'hFFFFFFF9, 32'd3, 1'b0, 1'b0);
        checkOutput("hi_const", 64'(hi), 64'hFFFFFFFF);
        checkOutput("lo_const", 64'(lo), 64'hFFFFFFEB);

        cur_step = "div_neg_b2b";
        applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        checkOutput("hi_const", 64'(hi), 64'hFFFFFFFF);
        checkOutput("lo_const", 64'(lo), 64'hFFFFFFFD);

        cur_step = "divu_zero";
        applyStimulus(2'b11, 32'd100, 32'd0, 1'b0, 1'b0);
        checkOutput("hi_const", 64'(hi), 64'd100);
        checkOutput("lo_const", 64'(lo), 64'hFFFFFFFF);
        checkOutput("dbz_const", 64'(div_by_zero), 64'd1);

        cur_step = "idle_moves";
        mthi = 1'b1; wdata = 32'd5;
        @(negedge clk);
        mthi = 1'b0;
        m_hi = 32'd5;
        checkOutput("hi_after_mthi", 64'(hi), 64'd5);
        checkOutput("lo_after_mthi", 64'(lo), 64'(m_lo));
        checkOutput("dbz_after_mthi", 64'(div_by_zero), 64'd1);
        mtlo = 1'b1; wdata = 32'd9;
        @(negedge clk);
        mtlo = 1'b0;
        m_lo = 32'd9;
        checkOutput("hi_after_mtlo", 64'(hi), 64'd5);
        checkOutput("lo_after_mtlo", 64'(lo), 64'd9);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_0F0F;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        m_hi = 32'hA5A5_0F0F; m_lo = 32'hA5A5_0F0F;
        checkOutput("hi_after_both", 64'(hi), 64'hA5A50F0F);
        checkOutput("lo_after_both", 64'(lo), 64'hA5A50F0F);

        cur_step = "divu_100_7";
        applyStimulus(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
        checkOutput("hi_const", 64'(hi), 64'd2);
        checkOutput("lo_const", 64'(lo), 64'd14);
        checkOutput("dbz_const", 64'(div_by_zero), 64'd0);

        cur_step = "div_min_m1";
        @(negedge clk);
        applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        checkOutput("hi_const", 64'(hi), 64'd0);
        checkOutput("lo_const", 64'(lo), 64'h80000000);

        cur_step = "disturbed_op";
        applyStimulus(2'b00, $urandom, $urandom, 1'b1, 1'b1);
        cur_step = "b2b_after_disturb";
        applyStimulus(2'b11, $urandom, 32'd13, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            cur_step = $sformatf("random%0d_op%0d", i, ro);
            applyStimulus(ro, ra, rb, 1'b0, 1'b0);
        end

        cur_step = "reset_mid_div";
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = $urandom; b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        checkOutput("busy", 64'(busy), 64'd0);
        checkOutput("done", 64'(done), 64'd0);
        checkOutput("hi", 64'(hi), 64'd0);
        checkOutput("lo", 64'(lo), 64'd0);
        checkOutput("div_by_zero", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        cur_step = "multu_after_reset";
        applyStimulus(2'b01, 32'd3, 32'd4, 1'b0, 1'b0);
        checkOutput("lo_const", 64'(lo), 64'd12);
        checkOutput("hi_const", 64'(hi), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
